// File: rtl/cursor_bar_multi_pkg.sv
// -----------------------------------------------------------------------------
// cursor_pkg
// Shared definitions for the multi-cursor overlay bar and its neighbours.
//   rep_state_t      : state encoding of the button auto-repeat FSM
//   CUR_POS_DEFAULT  : default geometry, shared with the single bar and mixer
//   CUR_STEP
//   CUR_POS_MIN
//   CUR_POS_MAX
//   idx_width()      : width of a cursor index, never less than one bit
// -----------------------------------------------------------------------------
package cursor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   localparam int CUR_POS_DEFAULT = 384;
   localparam int CUR_STEP        = 12;
   localparam int CUR_POS_MIN     = 12;
   localparam int CUR_POS_MAX     = 756;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cursor_bar_multi_if.sv
// -----------------------------------------------------------------------------
// cursor_bar_multi_if
// Button, coordinate and overlay signals of the multi-cursor bar.
//   btn_inc, btn_dec, btn_sel : debounced button levels (master -> slave)
//   coord_visible             : visible pixel coordinate on the cursor axis
//   in_line                   : per-cursor hit flags (slave -> master)
//   in_active_line            : hit flag of the selected cursor
//   active_idx                : index of the selected cursor
//   pos_flat                  : all cursor positions, cursor i at [i*COORD_W +: COORD_W]
// The cursor block connects to the slave modport, its driver to master.
// -----------------------------------------------------------------------------
interface cursor_bar_multi_if #(
   parameter int N_CURSORS = 2,
   parameter int COORD_W   = 11
);
   localparam int IDX_W = cursor_pkg::idx_width(N_CURSORS);

   logic                           btn_inc;
   logic                           btn_dec;
   logic                           btn_sel;
   logic [COORD_W-1:0]             coord_visible;
   logic [N_CURSORS-1:0]           in_line;
   logic                           in_active_line;
   logic [IDX_W-1:0]               active_idx;
   logic [N_CURSORS*COORD_W-1:0]   pos_flat;

   modport master (
      output btn_inc, btn_dec, btn_sel, coord_visible,
      input  in_line, in_active_line, active_idx, pos_flat
   );

   modport slave (
      input  btn_inc, btn_dec, btn_sel, coord_visible,
      output in_line, in_active_line, active_idx, pos_flat
   );
endinterface

// File: rtl/cursor_bar_multi_btn_autorepeat.sv
// -----------------------------------------------------------------------------
// btn_autorepeat
// Turns a held button level into step pulses: one pulse on press, one more
// after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   btn      : button level to repeat
//   inhibit  : opposing button level; while both are held no step is issued
//   step     : single-cycle step pulse
// -----------------------------------------------------------------------------
module btn_autorepeat
   import cursor_pkg::*;
#(
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic inhibit,
   output logic step
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_timing
      $error("btn_autorepeat: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   rep_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_q, btn_d;
   logic             inh_q, inh_d;
   logic             hold;

   // Registered levels: the FSM reacts one cycle after the button changes.
   assign btn_d = btn;
   assign inh_d = inhibit;
   assign hold  = btn_q && !inh_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         btn_q   <= 1'b0;
         inh_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_d;
         inh_q   <= inh_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!hold) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_DELAY;
               cnt_d   = '0;
            end
            ST_DELAY: begin
               if (cnt_q == DLY_LAST) begin
                  state_d = ST_REPEAT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_REPEAT: begin
               if (cnt_q == PER_LAST) cnt_d = '0;
               else                   cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      step = 1'b0;
      if (hold) begin
         case (state_q)
            ST_IDLE:   step = 1'b1;
            ST_DELAY:  step = (cnt_q == DLY_LAST);
            ST_REPEAT: step = (cnt_q == PER_LAST);
            default:   step = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/cursor_bar_multi.sv
// -----------------------------------------------------------------------------
// cursor_bar_multi
// N_CURSORS independent cursor positions on one screen axis for the scope
// VGA overlay. btn_inc/btn_dec move the selected cursor with auto-repeat,
// btn_sel cycles the selection, and per-pixel hit flags are produced against
// the current visible coordinate (vc_visible for horizontal lines, hc_visible
// for vertical ones).
//   clk_fpga : system clock
//   rst_n    : asynchronous active-low reset
//   cb       : cursor_bar_multi_if.slave (buttons, coordinate, hit flags,
//              active index, flattened positions)
// -----------------------------------------------------------------------------
module cursor_bar_multi
   import cursor_pkg::*;
#(
   parameter int N_CURSORS     = 2,
   parameter int COORD_W       = 11,
   parameter int POS_DEFAULT   = CUR_POS_DEFAULT,
   parameter int STEP          = CUR_STEP,
   parameter int POS_MIN       = CUR_POS_MIN,
   parameter int POS_MAX       = CUR_POS_MAX,
   parameter int LINE_W        = 1,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic                clk_fpga,
   input  logic                rst_n,
   cursor_bar_multi_if.slave   cb
);

   localparam int IDX_W = idx_width(N_CURSORS);
   localparam int EXT_W = COORD_W + 1;

   localparam logic [EXT_W-1:0]   STEP_X = EXT_W'(STEP);
   localparam logic [EXT_W-1:0]   MIN_X  = EXT_W'(POS_MIN);
   localparam logic [EXT_W-1:0]   MAX_X  = EXT_W'(POS_MAX);
   localparam logic [EXT_W-1:0]   LINE_X = EXT_W'(LINE_W);
   localparam logic [COORD_W-1:0] DEF_C  = COORD_W'(POS_DEFAULT);

   if (N_CURSORS < 1 || N_CURSORS > 8) begin : g_bad_n
      $error("cursor_bar_multi: N_CURSORS must be 1..8");
   end
   if (LINE_W < 1 || LINE_W > 8) begin : g_bad_line
      $error("cursor_bar_multi: LINE_W must be 1..8");
   end
   if (!(POS_MIN <= POS_DEFAULT && POS_DEFAULT <= POS_MAX && POS_MAX < (1 << COORD_W))) begin : g_bad_geom
      $error("cursor_bar_multi: need POS_MIN <= POS_DEFAULT <= POS_MAX < 2**COORD_W");
   end

   // Saturating moves in one extra bit so neither direction can wrap.
   function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] p);
      logic [EXT_W-1:0] sum;
      logic [EXT_W-1:0] res;
      sum = {1'b0, p} + STEP_X;
      res = (sum > MAX_X) ? MAX_X : sum;
      return res[COORD_W-1:0];
   endfunction

   function automatic logic [COORD_W-1:0] sat_dec(input logic [COORD_W-1:0] p);
      logic [EXT_W-1:0] res;
      if ({1'b0, p} < MIN_X + STEP_X) res = MIN_X;
      else                            res = {1'b0, p} - STEP_X;
      return res[COORD_W-1:0];
   endfunction

   logic               step_inc;
   logic               step_dec;
   logic [COORD_W-1:0] pos_q [N_CURSORS];
   logic [COORD_W-1:0] pos_d [N_CURSORS];
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               sel_q, sel_d;

   // Each move button inhibits the other: pressing both freezes the cursor.
   btn_autorepeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_rep_inc (
      .clk     (clk_fpga),
      .rst_n   (rst_n),
      .btn     (cb.btn_inc),
      .inhibit (cb.btn_dec),
      .step    (step_inc)
   );

   btn_autorepeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_rep_dec (
      .clk     (clk_fpga),
      .rst_n   (rst_n),
      .btn     (cb.btn_dec),
      .inhibit (cb.btn_inc),
      .step    (step_dec)
   );

   always_ff @(posedge clk_fpga or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CURSORS; i++) pos_q[i] <= DEF_C;
         idx_q <= '0;
         sel_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_CURSORS; i++) pos_q[i] <= pos_d[i];
         idx_q <= idx_d;
         sel_q <= sel_d;
      end
   end

   // A step uses the index held this cycle, so a simultaneous selection
   // edge moves the old cursor and only then advances.
   always_comb begin
      for (int i = 0; i < N_CURSORS; i++) begin
         pos_d[i] = pos_q[i];
         if (IDX_W'(i) == idx_q) begin
            if (step_inc)      pos_d[i] = sat_inc(pos_q[i]);
            else if (step_dec) pos_d[i] = sat_dec(pos_q[i]);
         end
      end
      sel_d = cb.btn_sel;
      idx_d = idx_q;
      if (cb.btn_sel && !sel_q) begin
         idx_d = (idx_q == IDX_W'(N_CURSORS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   logic [N_CURSORS-1:0]         in_line_c;
   logic                         in_active_c;
   logic [N_CURSORS*COORD_W-1:0] pos_flat_c;

   always_comb begin
      in_line_c   = '0;
      in_active_c = 1'b0;
      pos_flat_c  = '0;
      for (int i = 0; i < N_CURSORS; i++) begin
         in_line_c[i] = ({1'b0, cb.coord_visible} >= {1'b0, pos_q[i]}) &&
                        ({1'b0, cb.coord_visible} <  ({1'b0, pos_q[i]} + LINE_X));
         pos_flat_c[i*COORD_W +: COORD_W] = pos_q[i];
      end
      for (int i = 0; i < N_CURSORS; i++) begin
         if (IDX_W'(i) == idx_q) in_active_c = in_line_c[i];
      end
   end

   assign cb.in_line        = in_line_c;
   assign cb.in_active_line = in_active_c;
   assign cb.active_idx     = idx_q;
   assign cb.pos_flat       = pos_flat_c;

endmodule

// File: tb/tb_cursor_bar_multi.sv
// -----------------------------------------------------------------------------
// tb_cursor_bar_multi
// Directed bench for cursor_bar_multi with N_CURSORS=3, LINE_W=3,
// REPEAT_DELAY=8, REPEAT_PERIOD=4. Stimulus pushes the expected position /
// index snapshot into a queue; a monitor pops one entry per observed change.
// Timed and boundary values are also compared directly.
// -----------------------------------------------------------------------------
module tb_cursor_bar_multi;

   localparam int N  = 3;
   localparam int CW = 11;
   localparam int IW = 2;

   typedef struct packed {
      logic [N*CW-1:0] pos;
      logic [IW-1:0]   idx;
   } exp_t;

   logic clk_fpga = 1'b0;
   logic rst_n    = 1'b0;
   always #5 clk_fpga = ~clk_fpga;

   cursor_bar_multi_if #(.N_CURSORS(N), .COORD_W(CW)) bus ();

   cursor_bar_multi #(
      .N_CURSORS     (N),
      .COORD_W       (CW),
      .POS_DEFAULT   (384),
      .STEP          (12),
      .POS_MIN       (12),
      .POS_MAX       (756),
      .LINE_W        (3),
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (4)
   ) dut (
      .clk_fpga (clk_fpga),
      .rst_n    (rst_n),
      .cb       (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   int   mpos[N];
   int   midx;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   function automatic logic [CW-1:0] pos_of(input int i);
      return bus.pos_flat[i*CW +: CW];
   endfunction

   function automatic logic [N*CW-1:0] flat_model();
      logic [N*CW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(mpos[i]);
      return r;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.pos = flat_model();
      e.idx = IW'(midx);
      sb_q.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) mpos[i] = 384;
      midx = 0;
      sb_q.delete();
   endtask

   task automatic model_step(input int dir, input bit push);
      int np;
      np = mpos[midx] + dir * 12;
      if (np > 756) np = 756;
      if (np < 12)  np = 12;
      if (np != mpos[midx]) begin
         mpos[midx] = np;
         if (push) push_exp();
      end
   endtask

   // One-cycle press of a move button, then settle.
   task automatic press(input int dir);
      model_step(dir, 1'b1);
      @(posedge clk_fpga); #1;
      if (dir > 0) bus.btn_inc = 1'b1;
      else         bus.btn_dec = 1'b1;
      @(posedge clk_fpga); #1;
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      repeat (3) @(posedge clk_fpga);
   endtask

   task automatic press_sel();
      midx = (midx + 1) % N;
      push_exp();
      @(posedge clk_fpga); #1;
      bus.btn_sel = 1'b1;
      @(posedge clk_fpga); #1;
      bus.btn_sel = 1'b0;
      repeat (2) @(posedge clk_fpga);
      #1;
   endtask

   // Scoreboard monitor: every change of positions or index consumes one entry.
   initial begin : monitor
      logic [N*CW-1:0] prev_pos;
      logic [IW-1:0]   prev_idx;
      exp_t            e;
      prev_pos = '0;
      prev_idx = '0;
      forever begin
         @(negedge clk_fpga);
         if (!rst_n) begin
            prev_pos = bus.pos_flat;
            prev_idx = bus.active_idx;
         end else if (bus.pos_flat !== prev_pos || bus.active_idx !== prev_idx) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got pos_flat=%h idx=%0d with no expected change",
                        bus.pos_flat, bus.active_idx);
            end else begin
               e = sb_q.pop_front();
               chk("sb_pos_flat", 64'(bus.pos_flat), 64'(e.pos));
               chk("sb_active_idx", 64'(bus.active_idx), 64'(e.idx));
            end
            prev_pos = bus.pos_flat;
            prev_idx = bus.active_idx;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int want;
      bus.btn_inc       = 1'b0;
      bus.btn_dec       = 1'b0;
      bus.btn_sel       = 1'b0;
      bus.coord_visible = '0;
      model_reset();

      // Reset state and hit flags at the default position
      repeat (3) @(posedge clk_fpga);
      #1;
      chk("rst_pos_flat", 64'(bus.pos_flat), 64'(flat_model()));
      chk("rst_idx", 64'(bus.active_idx), 64'd0);
      rst_n = 1'b1;
      bus.coord_visible = 11'd384;
      #1;
      chk("hit_384_in_line", 64'(bus.in_line), 64'b111);
      chk("hit_384_active", 64'(bus.in_active_line), 64'd1);
      bus.coord_visible = 11'd387;
      #1;
      chk("hit_387_in_line", 64'(bus.in_line), 64'b000);
      bus.coord_visible = 11'd0;

      // Single press: pos[0] becomes 396 on the second edge after the rise
      model_step(1, 1'b1);
      @(posedge clk_fpga); #1;
      bus.btn_inc = 1'b1;
      @(posedge clk_fpga); #1;
      bus.btn_inc = 1'b0;
      #2 chk("single_pos0_edge1", 64'(pos_of(0)), 64'd384);
      @(posedge clk_fpga); #3;
      chk("single_pos0_edge2", 64'(pos_of(0)), 64'd396);
      chk("single_pos1", 64'(pos_of(1)), 64'd384);
      chk("single_pos2", 64'(pos_of(2)), 64'd384);
      repeat (4) @(posedge clk_fpga);

      // Asynchronous reset in the middle of a cycle
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_pos_flat", 64'(bus.pos_flat), 64'({11'd384, 11'd384, 11'd384}));
      chk("async_rst_idx", 64'(bus.active_idx), 64'd0);
      model_reset();
      @(posedge clk_fpga); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk_fpga);

      // Auto-repeat: btn_dec held for 20 edges
      for (int k = 0; k < 4; k++) model_step(-1, 1'b1);
      @(posedge clk_fpga); #1;
      bus.btn_dec = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         @(posedge clk_fpga); #1;
         if (n == 20) bus.btn_dec = 1'b0;
         want = (n < 2) ? 384 : (n < 10) ? 372 : (n < 14) ? 360 : (n < 18) ? 348 : 336;
         #2 chk($sformatf("hold_dec_edge%0d", n), 64'(pos_of(0)), 64'(want));
      end
      repeat (4) @(posedge clk_fpga);

      // Saturation at the top and bottom limits
      while (mpos[0] < 756) press(1);
      chk("sat_max_reach", 64'(pos_of(0)), 64'd756);
      for (int k = 0; k < 3; k++) begin
         press(1);
         chk($sformatf("sat_max_hold%0d", k), 64'(pos_of(0)), 64'd756);
      end
      while (mpos[0] > 24) press(-1);
      chk("sat_min_24", 64'(pos_of(0)), 64'd24);
      for (int k = 0; k < 3; k++) begin
         press(-1);
         chk($sformatf("sat_min_hold%0d", k), 64'(pos_of(0)), 64'd12);
      end

      // Selection cycles and wraps
      press_sel();
      chk("sel_idx1", 64'(bus.active_idx), 64'd1);
      press_sel();
      chk("sel_idx2", 64'(bus.active_idx), 64'd2);
      press_sel();
      chk("sel_idx0", 64'(bus.active_idx), 64'd0);
      press_sel();
      press_sel();
      press(1);
      chk("sel2_pos2", 64'(pos_of(2)), 64'd396);
      chk("sel2_pos0", 64'(pos_of(0)), 64'd12);
      chk("sel2_pos1", 64'(pos_of(1)), 64'd384);

      // Selection edge in the same cycle as a step: old cursor moves
      model_step(1, 1'b0);
      midx = 0;
      push_exp();
      @(posedge clk_fpga); #1;
      bus.btn_inc = 1'b1;
      @(posedge clk_fpga); #1;
      bus.btn_inc = 1'b0;
      bus.btn_sel = 1'b1;
      @(posedge clk_fpga); #1;
      bus.btn_sel = 1'b0;
      #2;
      chk("same_cycle_pos2", 64'(pos_of(2)), 64'd408);
      chk("same_cycle_pos0", 64'(pos_of(0)), 64'd12);
      chk("same_cycle_idx", 64'(bus.active_idx), 64'd0);
      repeat (3) @(posedge clk_fpga);

      // Conflict: both move buttons held on cursor 1
      press_sel();
      @(posedge clk_fpga); #1;
      bus.btn_inc = 1'b1;
      bus.btn_dec = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk_fpga);
         if (n % 10 == 0) begin
            #3 chk($sformatf("conflict_pos1_%0d", n), 64'(pos_of(1)), 64'd384);
         end
      end
      #1;
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      repeat (12) @(posedge clk_fpga);
      #3 chk("conflict_after", 64'(bus.pos_flat), 64'({11'd408, 11'd384, 11'd12}));

      // Line thickness 3 around cursor 1 at 396
      press(1);
      chk("thick_pos1", 64'(pos_of(1)), 64'd396);
      bus.coord_visible = 11'd395; #1;
      chk("thick_395", 64'({bus.in_line[1], bus.in_active_line}), 64'b00);
      bus.coord_visible = 11'd396; #1;
      chk("thick_396", 64'({bus.in_line[1], bus.in_active_line}), 64'b11);
      bus.coord_visible = 11'd398; #1;
      chk("thick_398", 64'({bus.in_line[1], bus.in_active_line}), 64'b11);
      bus.coord_visible = 11'd399; #1;
      chk("thick_399", 64'({bus.in_line[1], bus.in_active_line}), 64'b00);
      bus.coord_visible = 11'd13; #1;
      chk("thick_cursor0_13", 64'(bus.in_line), 64'b001);

      repeat (5) @(posedge clk_fpga);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
